// File: rtl/vga_layer_mixer.sv
// Two-stage pixel compositor: background select, sprite priority, blanking.
// Optional fade-to-black on background switch: define VGA_MIXER_FADE_EN.
module vga_layer_mixer #(
   parameter  int CW          = 2,
   parameter  int NUM_BG      = 4,
   parameter  int NUM_LAYERS  = 2,
   parameter  int FC_W        = 10,
   parameter  int FADE_FRAMES = 4,
   parameter  bit SYNC_ACTIVE = 1'b0,
   localparam int SW          = (NUM_BG > 1) ? $clog2(NUM_BG) : 1
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       hsync_in,
   input  logic                       vsync_in,
   input  logic                       video_active,
   input  logic [SW-1:0]              bg_sel,
   input  logic [NUM_BG*3*CW-1:0]     bg_rgb,
   input  logic [NUM_LAYERS*3*CW-1:0] layer_rgb,
   input  logic [NUM_LAYERS-1:0]      layer_hit,
   input  logic [NUM_LAYERS-1:0]      layer_en,
   output logic [CW-1:0]              R,
   output logic [CW-1:0]              G,
   output logic [CW-1:0]              B,
   output logic                       hsync_out,
   output logic                       vsync_out,
   output logic [FC_W-1:0]            frame_cnt,
   output logic [SW-1:0]              active_bg,
   output logic                       busy
);

   localparam int PW = 3 * CW;
   localparam int LW = $clog2(CW + 1);

   logic          s1_hs;
   logic          s1_vs;
   logic          s1_va;
   logic [PW-1:0] s1_rgb;
   logic [PW-1:0] mix_rgb;
   logic [SW-1:0] bg_idx;
   logic [LW-1:0] fade_lvl;
   logic          frame_tick;

   // Boundary: stage-1 vsync just became active, stage-2 copy not yet.
   assign frame_tick = (s1_vs == SYNC_ACTIVE) && (vsync_out != SYNC_ACTIVE);

   // Resolve requested background; out-of-range indices fall back to 0.
   always_comb begin
      bg_idx = '0;
      for (int i = 0; i < NUM_BG; i++) begin
         if (bg_sel == SW'(i)) begin
            bg_idx = bg_sel;
         end
      end
   end

   // Pick the active background, then let the lowest-index sprite win.
   always_comb begin
      mix_rgb = '0;
      for (int i = 0; i < NUM_BG; i++) begin
         if (active_bg == SW'(i)) begin
            mix_rgb = bg_rgb[i*PW +: PW];
         end
      end
      for (int i = NUM_LAYERS - 1; i >= 0; i--) begin
         if (layer_hit[i] && layer_en[i]) begin
            mix_rgb = layer_rgb[i*PW +: PW];
         end
      end
   end

   // Stage 1: register composited colour alongside syncs and qualifier.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_hs  <= ~SYNC_ACTIVE;
         s1_vs  <= ~SYNC_ACTIVE;
         s1_va  <= 1'b0;
         s1_rgb <= '0;
      end else begin
         s1_hs  <= hsync_in;
         s1_vs  <= vsync_in;
         s1_va  <= video_active;
         s1_rgb <= mix_rgb;
      end
   end

   // Stage 2: blank outside active video and apply the fade shift.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hsync_out <= ~SYNC_ACTIVE;
         vsync_out <= ~SYNC_ACTIVE;
         R         <= '0;
         G         <= '0;
         B         <= '0;
      end else begin
         hsync_out <= s1_hs;
         vsync_out <= s1_vs;
         if (s1_va) begin
            R <= s1_rgb[2*CW +: CW] >> fade_lvl;
            G <= s1_rgb[CW +: CW] >> fade_lvl;
            B <= s1_rgb[0 +: CW] >> fade_lvl;
         end else begin
            R <= '0;
            G <= '0;
            B <= '0;
         end
      end
   end

   // Frame counter advances once per frame boundary and wraps naturally.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         frame_cnt <= '0;
      end else if (frame_tick) begin
         frame_cnt <= frame_cnt + FC_W'(1);
      end
   end

`ifdef VGA_MIXER_FADE_EN

   localparam int FW = $clog2(FADE_FRAMES + 1);

   typedef enum logic [1:0] {
      IDLE,
      FADE_OUT,
      SWAP,
      FADE_IN
   } fade_state_t;

   fade_state_t   state;
   logic [FW-1:0] step_cnt;
   logic          step_done;

   assign step_done = (step_cnt == FW'(FADE_FRAMES - 1));

   // Frame-paced fade: dim out, swap background, brighten back in.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         step_cnt  <= '0;
         fade_lvl  <= '0;
         active_bg <= '0;
         busy      <= 1'b0;
      end else if (frame_tick) begin
         unique case (state)
            IDLE: begin
               if (bg_idx != active_bg) begin
                  state    <= FADE_OUT;
                  step_cnt <= '0;
                  fade_lvl <= '0;
                  busy     <= 1'b1;
               end
            end
            FADE_OUT: begin
               if (step_done) begin
                  step_cnt <= '0;
                  fade_lvl <= fade_lvl + LW'(1);
                  if (fade_lvl == LW'(CW - 1)) begin
                     state <= SWAP;
                  end
               end else begin
                  step_cnt <= step_cnt + FW'(1);
               end
            end
            SWAP: begin
               active_bg <= bg_idx;
               step_cnt  <= '0;
               state     <= FADE_IN;
            end
            FADE_IN: begin
               if (step_done) begin
                  step_cnt <= '0;
                  fade_lvl <= fade_lvl - LW'(1);
                  if (fade_lvl == LW'(1)) begin
                     state <= IDLE;
                     busy  <= 1'b0;
                  end
               end else begin
                  step_cnt <= step_cnt + FW'(1);
               end
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

`else

   assign fade_lvl = '0;
   assign busy     = 1'b0;

   // Without fade the background switches directly at the boundary.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         active_bg <= '0;
      end else if (frame_tick) begin
         active_bg <= bg_idx;
      end
   end

`endif

endmodule
